clock_counter_spim: RTL and testbench

CLOCK_COUNTER_SPIM -- requirements
Module: clock_counter_spim

---
 rtl/clock_counter_spim_if.sv | 15 +
 rtl/clock_counter_spim.sv | 102 ++++++++++
 tb/tb_clock_counter_spim.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/clock_counter_spim_if.sv
// clock_counter_spim_if: control bus of clock_counter_spim.
// The master issues start/tx_data; the slave returns busy, done, rx_count and freq_err.
interface clock_counter_spim_if #(
    parameter int TX_BITS = 28,
    parameter int RX_BITS = 16
);
    logic               start;
    logic [TX_BITS-1:0] tx_data;
    logic               busy;
    logic               done;
    logic [RX_BITS-1:0] rx_count;
    logic [RX_BITS:0]   freq_err;
    modport master (output start, tx_data, input busy, done, rx_count, freq_err);
    modport slave  (input start, tx_data, output busy, done, rx_count, freq_err);
endinterface

// File: rtl/clock_counter_spim.sv
// clock_counter_spim: SPI master that sends a compare value to a clock counter and reads back its count.
// Define CLOCK_COUNTER_SPIM_ERR_EN to register freq_err = rx_count - NOMINAL; otherwise freq_err is tied to 0.
module clock_counter_spim #(
    parameter int                 CLK_DIV = 4,
    parameter int                 TX_BITS = 28,
    parameter int                 RX_BITS = 16,
    parameter logic [RX_BITS-1:0] NOMINAL = '0
) (
    input  logic                 clk,
    input  logic                 nreset,
    clock_counter_spim_if.slave  bus,
    output logic                 spi_clk,
    output logic                 spi_sen,
    output logic                 spi_mosi,
    input  logic                 spi_miso
);
    localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
    localparam int IW = TX_BITS > 1 ? $clog2(TX_BITS) : 1;
    localparam logic [DW-1:0] DIV_END = DW'(CLK_DIV - 1);
    localparam logic [IW-1:0] BIT_END = IW'(TX_BITS - 1);
    localparam logic [IW-1:0] RX_END  = IW'(RX_BITS - 1);

    typedef enum logic [2:0] {IDLE, LEAD, HIGH, LOW, DONE} state_t;

    state_t             state;
    logic [DW-1:0]      div;
    logic [IW-1:0]      bit_idx;
    logic [TX_BITS-2:0] tx_sr;
    logic [RX_BITS-1:0] rx_sr;
    logic               tick;
    logic               finish;

    assign tick   = div == DIV_END;
    assign finish = state == LOW && tick && bit_idx == BIT_END;

    always_ff @(posedge clk) begin
        if (!nreset) begin
            state        <= IDLE;
            div          <= '0;
            bit_idx      <= '0;
            tx_sr        <= '0;
            rx_sr        <= '0;
            spi_clk      <= 1'b0;
            spi_sen      <= 1'b0;
            spi_mosi     <= 1'b0;
            bus.busy     <= 1'b0;
            bus.done     <= 1'b0;
            bus.rx_count <= '0;
        end else begin
            bus.done <= 1'b0;
            div      <= (state == IDLE || state == DONE || tick) ? '0 : div + 1'b1;
            case (state)
                IDLE: if (bus.start) begin
                    tx_sr    <= bus.tx_data[TX_BITS-2:0];
                    spi_mosi <= bus.tx_data[TX_BITS-1];
                    spi_sen  <= 1'b1;
                    bus.busy <= 1'b1;
                    bit_idx  <= '0;
                    state    <= LEAD;
                end
                LEAD: if (tick) begin
                    spi_clk <= 1'b1;
                    rx_sr   <= {rx_sr[RX_BITS-2:0], spi_miso};
                    state   <= HIGH;
                end
                HIGH: if (tick) begin
                    spi_clk  <= 1'b0;
                    spi_mosi <= tx_sr[TX_BITS-2];
                    tx_sr    <= tx_sr << 1;
                    state    <= LOW;
                end
                LOW: if (tick) begin
                    if (finish) begin
                        spi_sen      <= 1'b0;
                        spi_mosi     <= 1'b0;
                        bus.busy     <= 1'b0;
                        bus.done     <= 1'b1;
                        bus.rx_count <= rx_sr;
                        state        <= DONE;
                    end else begin
                        // bit_idx is the index just finished; the next rising edge carries bit_idx+1
                        spi_clk <= 1'b1;
                        bit_idx <= bit_idx + 1'b1;
                        if (bit_idx < RX_END) rx_sr <= {rx_sr[RX_BITS-2:0], spi_miso};
                        state   <= HIGH;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef CLOCK_COUNTER_SPIM_ERR_EN
    always_ff @(posedge clk) begin
        if (!nreset) bus.freq_err <= '0;
        else if (finish) bus.freq_err <= {rx_sr[RX_BITS-1], rx_sr} - {NOMINAL[RX_BITS-1], NOMINAL};
    end
`else
    // masked to zero so no subtractor is built while NOMINAL stays referenced
    assign bus.freq_err = {1'b0, NOMINAL} & '0;
`endif
endmodule

// File: tb/tb_clock_counter_spim.sv
// tb_clock_counter_spim: randomized frames against a behavioural counter slave and a scoreboard.
// Covers latency, ignored starts, mid-frame reset and the freq_err configuration.
module tb_clock_counter_spim;
    localparam int TXB = 28;
    localparam int RXB = 16;
    localparam int DIV = 4;
    localparam int LAT = (2 * TXB + 1) * DIV + 1;
    localparam logic [RXB-1:0] NOM = 16'hA5C0;

    logic clk = 1'b0;
    logic nreset = 1'b0;
    logic spi_clk, spi_sen, spi_mosi, spi_miso;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;

    clock_counter_spim_if #(.TX_BITS(TXB), .RX_BITS(RXB)) bus ();

    clock_counter_spim #(.CLK_DIV(DIV), .TX_BITS(TXB), .RX_BITS(RXB), .NOMINAL(NOM)) dut (
        .clk(clk),
        .nreset(nreset),
        .bus(bus),
        .spi_clk(spi_clk),
        .spi_sen(spi_sen),
        .spi_mosi(spi_mosi),
        .spi_miso(spi_miso)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [TXB-1:0] tx;
        logic [RXB-1:0] rx;
        int             at;
    } exp_t;
    exp_t exp_q[$];

    // counter slave: shifts cload out MSB first, advancing on each falling spi_clk
    logic [RXB-1:0] cload = '0;
    logic           mosi_log[$];
    int             falls = 0;
    int             base_fall = 0;
    int             base_rise = 0;
    always @(negedge spi_clk) falls <= falls + 1;
    always @(posedge spi_clk) mosi_log.push_back(spi_mosi);
    always @(posedge spi_sen) begin
        base_fall = falls;
        base_rise = mosi_log.size();
    end
    assign spi_miso = (falls - base_fall < RXB) ? cload[RXB-1-(falls-base_fall)] : 1'b0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    function automatic logic [RXB:0] ferr(input logic [RXB-1:0] c);
`ifdef CLOCK_COUNTER_SPIM_ERR_EN
        int d;
        d = int'($signed(c)) - int'($signed(NOM));
        return d[RXB:0];
`else
        return '0;
`endif
    endfunction

    logic prev_done = 1'b0;
    always @(negedge clk) begin : monitor
        exp_t           e;
        logic [TXB-1:0] bits;
        if (bus.done) begin
            check("done_pulse", prev_done, 0);
            if (exp_q.size() == 0) check("unexpected_done", bus.done, 0);
            else begin
                e = exp_q.pop_front();
                check("done_cycle", cyc, e.at);
                check("rx_count", bus.rx_count, e.rx);
                check("freq_err", bus.freq_err, ferr(e.rx));
                check("sclk_rises", mosi_log.size() - base_rise, TXB);
                bits = '0;
                for (int i = base_rise; i < mosi_log.size(); i++) bits = {bits[TXB-2:0], mosi_log[i]};
                check("mosi_bits", bits, e.tx);
                check("busy_at_done", bus.busy, 0);
                check("sen_at_done", spi_sen, 0);
            end
        end
        prev_done <= bus.done;
    end

    task automatic frame(input logic [TXB-1:0] tx, input logic [RXB-1:0] cl, input bit extra, input int abort_at);
        int s;
        @(negedge clk);
        cload       = cl;
        bus.start   = 1'b1;
        bus.tx_data = tx;
        s           = cyc;
        if (abort_at == 0) exp_q.push_back('{tx, cl, s + LAT});
        for (int k = 1; k <= LAT; k++) begin
            @(negedge clk);
            bus.start = extra && (k == 10 || k == LAT - 1 || k == LAT);
            if (bus.start) bus.tx_data = TXB'($urandom);
            if (k == 1) begin
                check("busy_start", bus.busy, 1);
                check("sen_start", spi_sen, 1);
            end
            if (k == abort_at) begin
                nreset = 1'b0;
                @(negedge clk);
                nreset = 1'b1;
                check("abort_outs", {spi_clk, spi_sen, spi_mosi, bus.busy, bus.done}, 0);
                check("abort_rx_count", bus.rx_count, 0);
                check("abort_freq_err", bus.freq_err, 0);
                return;
            end
        end
    endtask

    initial begin
        bus.start   = 1'b0;
        bus.tx_data = '0;
        repeat (3) @(negedge clk);
        check("rst_outs", {spi_clk, spi_sen, spi_mosi, bus.busy, bus.done}, 0);
        check("rst_rx_count", bus.rx_count, 0);
        check("rst_freq_err", bus.freq_err, 0);
        nreset = 1'b1;
        frame(28'h0ABCDEF, 16'hA5C3, 1'b1, 0);
        frame(TXB'($urandom), RXB'($urandom), 1'b0, 0);
        frame(TXB'($urandom), RXB'($urandom), 1'b0, 100);
        frame(TXB'($urandom), 16'h0001, 1'b0, 0);
        frame(28'hFFFFFFF, 16'hFFFF, 1'b0, 0);
        frame(28'h0000000, 16'h8000, 1'b1, 0);
        repeat (6) frame(TXB'($urandom), RXB'($urandom), 1'($urandom_range(0, 1)), 0);
        for (int i = 0; i < 400 && exp_q.size() > 0; i++) @(negedge clk);
        if (exp_q.size() > 0) check("missing_done", exp_q.size(), 0);
        repeat (5) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
